// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [NUM_REQ*WIDTH-1:0] i_data,
   output logic [NUM_REQ-1:0]       o_ack,
   input  logic                     i_fifo_full,
   output logic                     o_fifo_wr_en,
   output logic [WIDTH-1:0]         o_fifo_wr_data,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic [IW-1:0]            o_grant_id,
   output logic                     o_busy
);
   localparam int BW = $clog2(MAX_BURST + 1);
   typedef enum logic {IDLE, GRANT} state_e;
   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [IW-1:0]        id_q, id_d, rr_ptr_q, rr_ptr_d, sel;
   logic [BW-1:0]        burst_q, burst_d;
   logic [IW:0]          idx;
   logic                 busy_q, found, req_g, accept, rel;
   logic [WIDTH-1:0]     data_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign data_a[g] = i_data[g*WIDTH +: WIDTH];
   end

   // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ (not 2**IW).
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr_q} + (IW+1)'(i);
         idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
         if (!found && i_req[idx[IW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IW-1:0];
         end
      end
   end

   assign req_g  = i_req[id_q];
   assign accept = (state_q == GRANT) && req_g && !i_fifo_full && !i_rst;
   assign rel    = (state_q == GRANT) && (!req_g || (accept && burst_q == BW'(MAX_BURST - 1)));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         id_q     <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         id_q     <= id_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
         busy_q   <= state_d == GRANT;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      id_d     = id_q;
      rr_ptr_d = rr_ptr_q;
      burst_d  = burst_q;
      if (state_q == IDLE && found) begin
         state_d = GRANT;
         grant_d = NUM_REQ'(1) << sel;
         id_d    = sel;
         burst_d = '0;
      end else if (rel) begin
         state_d  = IDLE;
         grant_d  = '0;
         id_d     = '0;
         burst_d  = '0;
         rr_ptr_d = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
      end else if (accept) begin
         burst_d = burst_q + 1'b1;
      end
   end

   always_comb begin
      o_ack          = accept ? grant_q : '0;
      o_fifo_wr_en   = accept;
      o_fifo_wr_data = accept ? data_a[id_q] : '0;
   end

   assign o_grant    = grant_q;
   assign o_grant_id = id_q;
   assign o_busy     = busy_q;
endmodule
